sata_tx_align_scheduler: RTL and testbench
==========================================

# sata_tx_align_scheduler

Transmit-side ALIGNp scheduler sitting between the link layer's outgoing dword stream and the PHY's 32-bit TX path, in the system clock domain.
- It emits a continuous ALIGNp stream while the PHY is not ready.
- Once ready, it inserts exactly one pair of ALIGNp after every ALIGN_PERIOD link dwords, stalling the link layer via `ready`.
- These pairs are the slack that the far end's receive elastic buffer skips or duplicates to absorb clock drift.

## Interface
- ALIGN_PERIOD, 254: link dwords between ALIGNp pairs; legal range 1..510 (254 gives one pair per 256 transmitted dwords).
- ALIGN_PRIM, 32'h7B4A4ABC: ALIGNp dword; sent with charisk 4'h1.
- CNT_BITS, 9: width of the dword counter; must hold ALIGN_PERIOD-1.
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- phy_ready  input  1  PHY link up; low forces a continuous ALIGNp stream.
- data_in  input  32  link-layer dword; held stable while not consumed.
- charisk_in  input  4  K-char flags for data_in.
- ready  output  1  registered; a dword is consumed at each posedge where ready=1.
- data_out  output  32  registered TX dword.
- charisk_out  output  4  registered TX K-char flags.
- align_strobe  output  1  registered; high during the cycle in which the second ALIGNp of a scheduled pair is on data_out.
- forcing  output  1  registered; high while in FORCE state.

## Operation
- States: FORCE, PASS, ALIGN1, ALIGN2. Counter `cnt`, width CNT_BITS. Parity bit `forced_odd`.
- Reset values: state=FORCE, cnt=0, forced_odd=0, ready=0, data_out=ALIGN_PRIM, charisk_out=4'h1, align_strobe=0, forcing=1.
- phy_ready=0 at any posedge has the highest priority:
  - next state=FORCE, data_out=ALIGN_PRIM, charisk_out=4'h1.
  - ready<=0, cnt<=0, align_strobe<=0.
  - forced_odd<=1 when entering from another state; otherwise it toggles.
- FORCE: each posedge emits one ALIGNp and toggles forced_odd.
  - Exit to PASS at a posedge only when phy_ready=1 and forced_odd=1, so that posedge's ALIGNp is the even-numbered one.
  - On exit, ready<=1 and cnt<=0.
  - The reset-value ALIGNp does not count. FORCE therefore always sends an even count of at least 2 ALIGNp.
- PASS, posedge with ready=1:
  - data_out<=data_in, charisk_out<=charisk_in.
  - If cnt==ALIGN_PERIOD-1: cnt<=0, ready<=0, next state=ALIGN1. Otherwise cnt<=cnt+1.
- ALIGN1, posedge: data_out=ALIGNp, next state=ALIGN2.
- ALIGN2, posedge: data_out=ALIGNp, align_strobe<=1, ready<=1, next state=PASS.
- align_strobe returns to 0 on the following posedge.
- data_in is not inspected: an ALIGNp supplied by the link layer counts as an ordinary dword.
- ALIGN_PERIOD=1: every link dword is followed by a pair; ready pattern 1,0,0 repeating.

## Timing
- Data latency: data_in consumed at posedge k appears on data_out from posedge k to posedge k+1.
- ready is registered:
  - It drops in the cycle after the ALIGN_PERIOD-th transfer and stays low for exactly 2 cycles.
  - The next transfer happens at posedge k+3, so data_out shows Dlast, ALIGNp, ALIGNp, Dnext with no bubble.
- Steady state: period of ALIGN_PERIOD+2 cycles, with ready high for ALIGN_PERIOD of them.
- phy_ready fall mid-pair (in ALIGN1 or ALIGN2): FORCE takes over on the next posedge. The pair is not completed as such; FORCE's even-count rule covers it.
- phy_ready fall while ready=1: the dword presented in that cycle is not consumed. ready drops at that same posedge, and the link layer must re-present the dword after recovery.
- rst asserted mid-operation: all registers return to their reset values on the next posedge, regardless of phy_ready.
- Wrap-around: cnt never exceeds ALIGN_PERIOD-1; no overflow for legal parameters.

## Test plan
- Reset, phy_ready=1 from the first cycle:
  - data_out=ALIGNp for 2 cycles after reset release (forcing=1).
  - ready=1 from cycle 3 onward.
  - First data dword appears one cycle after the first transfer.
- ALIGN_PERIOD=254, incrementing data_in, ready honoured, 3000 cycles:
  - Output is exactly 254 sequential dwords then 2 ALIGNp, repeated.
  - align_strobe fires every 256 cycles.
  - No dword is lost or duplicated.
- phy_ready deasserted for 1 cycle in PASS at cnt=100:
  - ALIGNp emitted for exactly 2 cycles.
  - Resumes with the unconsumed dword; cnt restarts at 0, so the next pair comes after 254 dwords.
- phy_ready dropped during ALIGN1, held low for 3 cycles, then raised:
  - 4 ALIGNp emitted in FORCE (odd count 3 padded to 4), then PASS.
- ALIGN_PERIOD=1:
  - data_out pattern D0,A,A,D1,A,A,...
  - ready pattern 1,0,0.
  - align_strobe once per 3 cycles.
- rst pulsed in ALIGN2:
  - Next posedge gives data_out=ALIGNp, charisk_out=4'h1, ready=0, align_strobe=0, forcing=1.

Source files
------------

// File: rtl/sata_tx_align_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sata_tx_align_scheduler
// Description : Transmit-side ALIGNp scheduler. Streams ALIGNp while the PHY
//               is down, and once up, inserts one ALIGNp pair after every
//               ALIGN_PERIOD link dwords, back-pressuring the link via ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sata_tx_align_scheduler #(
    parameter int          ALIGN_PERIOD = 254,
    parameter logic [31:0] ALIGN_PRIM   = 32'h7B4A4ABC,
    parameter int          CNT_BITS     = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic [31:0] data_in,
    input  logic [3:0]  charisk_in,
    output logic        ready,
    output logic [31:0] data_out,
    output logic [3:0]  charisk_out,
    output logic        align_strobe,
    output logic        forcing
);

    localparam logic [1:0]          c_force  = 2'd0;
    localparam logic [1:0]          c_pass   = 2'd1;
    localparam logic [1:0]          c_align1 = 2'd2;
    localparam logic [1:0]          c_align2 = 2'd3;
    localparam logic [3:0]          c_k_align = 4'h1;
    localparam logic [CNT_BITS-1:0] c_last   = CNT_BITS'(ALIGN_PERIOD - 1);

    logic [1:0]          r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_forced_odd;
    logic                r_ready;
    logic [31:0]         r_data;
    logic [3:0]          r_charisk;
    logic                r_strobe;
    logic                r_forcing;

    logic [1:0]          w_state_nxt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic                w_odd_nxt;
    logic                w_ready_nxt;
    logic [31:0]         w_data_nxt;
    logic [3:0]          w_charisk_nxt;
    logic                w_strobe_nxt;
    logic                w_period_done;

    // The ALIGN_PERIOD-th link dword is being consumed this cycle
    assign w_period_done = r_ready && (r_cnt == c_last);

    // State and output registers; reset restores the FORCE-state defaults
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_force;
            r_cnt        <= '0;
            r_forced_odd <= 1'b0;
            r_ready      <= 1'b0;
            r_data       <= ALIGN_PRIM;
            r_charisk    <= c_k_align;
            r_strobe     <= 1'b0;
            r_forcing    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_forced_odd <= w_odd_nxt;
            r_ready      <= w_ready_nxt;
            r_data       <= w_data_nxt;
            r_charisk    <= w_charisk_nxt;
            r_strobe     <= w_strobe_nxt;
            r_forcing    <= (w_state_nxt == c_force);
        end
    end

    // Next-state selection; a PHY drop overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (!phy_ready) begin
            w_state_nxt = c_force;
        end else begin
            case (r_state)
                // Leave only after an even number of forced ALIGNp
                c_force:  w_state_nxt = r_forced_odd ? c_pass : c_force;
                c_pass:   w_state_nxt = w_period_done ? c_align1 : c_pass;
                c_align1: w_state_nxt = c_align2;
                c_align2: w_state_nxt = c_pass;
                default:  w_state_nxt = c_force;
            endcase
        end
    end

    // Next values of the registered outputs, counter and forced-count parity
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_odd_nxt     = r_forced_odd;
        w_ready_nxt   = r_ready;
        w_data_nxt    = r_data;
        w_charisk_nxt = r_charisk;
        w_strobe_nxt  = 1'b0;
        if (!phy_ready) begin
            // The offered dword is not consumed; the link re-presents it later
            w_data_nxt    = ALIGN_PRIM;
            w_charisk_nxt = c_k_align;
            w_ready_nxt   = 1'b0;
            w_cnt_nxt     = '0;
            w_odd_nxt     = (r_state != c_force) ? 1'b1 : ~r_forced_odd;
        end else begin
            case (r_state)
                c_force: begin
                    w_data_nxt    = ALIGN_PRIM;
                    w_charisk_nxt = c_k_align;
                    w_odd_nxt     = ~r_forced_odd;
                    w_ready_nxt   = r_forced_odd;
                    w_cnt_nxt     = '0;
                end
                c_pass: begin
                    if (r_ready) begin
                        w_data_nxt    = data_in;
                        w_charisk_nxt = charisk_in;
                        if (w_period_done) begin
                            w_cnt_nxt   = '0;
                            w_ready_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                c_align1: begin
                    w_data_nxt    = ALIGN_PRIM;
                    w_charisk_nxt = c_k_align;
                    w_ready_nxt   = 1'b0;
                end
                c_align2: begin
                    // Re-open ready now so the next dword follows with no bubble
                    w_data_nxt    = ALIGN_PRIM;
                    w_charisk_nxt = c_k_align;
                    w_strobe_nxt  = 1'b1;
                    w_ready_nxt   = 1'b1;
                end
                default: begin
                    w_data_nxt    = ALIGN_PRIM;
                    w_charisk_nxt = c_k_align;
                    w_ready_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign data_out     = r_data;
    assign charisk_out  = r_charisk;
    assign align_strobe = r_strobe;
    assign forcing      = r_forcing;

endmodule
`default_nettype wire

// File: tb/tb_sata_tx_align_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sata_tx_align_scheduler
// Description : Directed self-checking bench for sata_tx_align_scheduler,
//               period 254 instance plus a period 1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sata_tx_align_scheduler;

    localparam logic [31:0] c_align = 32'h7B4A4ABC;
    localparam logic [31:0] c_base  = 32'h1000_0000;
    localparam logic [31:0] c_base1 = 32'h2000_0000;

    logic        clk;
    logic        rst;
    logic        phy_ready;
    logic [31:0] data_in,  data_in1;
    logic [3:0]  charisk_in, charisk_in1;
    logic        ready, ready1;
    logic [31:0] data_out, data_out1;
    logic [3:0]  charisk_out, charisk_out1;
    logic        align_strobe, align_strobe1;
    logic        forcing, forcing1;

    int checks = 0;
    int errors = 0;
    int seq    = 0;
    int seq1   = 0;

    sata_tx_align_scheduler #(.ALIGN_PERIOD(254), .ALIGN_PRIM(c_align), .CNT_BITS(9)) dut (
        .clk(clk), .rst(rst), .phy_ready(phy_ready),
        .data_in(data_in), .charisk_in(charisk_in),
        .ready(ready), .data_out(data_out), .charisk_out(charisk_out),
        .align_strobe(align_strobe), .forcing(forcing)
    );

    sata_tx_align_scheduler #(.ALIGN_PERIOD(1), .ALIGN_PRIM(c_align), .CNT_BITS(9)) dut1 (
        .clk(clk), .rst(rst), .phy_ready(phy_ready),
        .data_in(data_in1), .charisk_in(charisk_in1),
        .ready(ready1), .data_out(data_out1), .charisk_out(charisk_out1),
        .align_strobe(align_strobe1), .forcing(forcing1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dw(input int k);
        return c_base + 32'(k);
    endfunction

    function automatic logic [3:0] ck(input int k);
        return 4'(k);
    endfunction

    function automatic logic [31:0] dw1(input int k);
        return c_base1 + 32'(k);
    endfunction

    task automatic drive();
        data_in     = dw(seq);
        charisk_in  = ck(seq);
        data_in1    = dw1(seq1);
        charisk_in1 = 4'h0;
    endtask

    // One clock: link layer advances its dword on every consumed posedge
    task automatic cyc();
        logic c0, c1;
        c0 = ready && phy_ready && !rst;
        c1 = ready1 && phy_ready && !rst;
        @(posedge clk);
        #1;
        if (c0) seq++;
        if (c1) seq1++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        phy_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        seq = 0;
        seq1 = 0;
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        phy_ready = 1'b0;
        seq = 0;
        seq1 = 0;
        drive();
        cyc();
        cyc();
        checks++;
        if (data_out !== c_align || charisk_out !== 4'h1 || ready !== 1'b0 ||
            align_strobe !== 1'b0 || forcing !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: data=%h k=%h rdy=%b stb=%b frc=%b required %h 1 0 0 1",
                     data_out, charisk_out, ready, align_strobe, forcing, c_align);
        end
        checks++;
        if (data_out1 !== c_align || ready1 !== 1'b0 || forcing1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_p1: data=%h rdy=%b frc=%b required %h 0 1",
                     data_out1, ready1, forcing1, c_align);
        end
        phy_ready = 1'b1;
        rst = 1'b0;
        cyc();
        checks++;
        if (data_out !== c_align || forcing !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_align: data=%h frc=%b rdy=%b required %h 1 0",
                     data_out, forcing, ready, c_align);
        end
        cyc();
        checks++;
        if (data_out !== c_align || ready !== 1'b1 || forcing !== 1'b0) begin
            errors++;
            $display("FAIL reset_second_align: data=%h rdy=%b frc=%b required %h 1 0",
                     data_out, ready, forcing, c_align);
        end
        cyc();
        checks++;
        if (data_out !== dw(0) || charisk_out !== ck(0)) begin
            errors++;
            $display("FAIL reset_first_data: data=%h k=%h required %h %h",
                     data_out, charisk_out, dw(0), ck(0));
        end
    endtask

    // Continues from D0 on data_out; checks 254 data / 2 ALIGNp cadence
    task automatic test_stream();
        int exp_idx = 1;
        int data_run = 1;
        int align_run = 0;
        int since_strobe = -1;
        int strobes = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (since_strobe >= 0) since_strobe++;
            if (data_out === c_align) begin
                checks++;
                if (charisk_out !== 4'h1) begin
                    errors++;
                    $display("FAIL stream_align_k: k=%h required 1", charisk_out);
                end
                if (align_run == 0) begin
                    checks++;
                    if (data_run != 254) begin
                        errors++;
                        $display("FAIL stream_data_run: got %0d dwords required 254", data_run);
                    end
                    data_run = 0;
                end
                align_run++;
                if (align_strobe === 1'b1) begin
                    strobes++;
                    checks++;
                    if (align_run != 2) begin
                        errors++;
                        $display("FAIL stream_strobe_pos: strobe on ALIGNp #%0d required #2", align_run);
                    end
                    if (since_strobe >= 0) begin
                        checks++;
                        if (since_strobe != 256) begin
                            errors++;
                            $display("FAIL stream_strobe_period: %0d cycles required 256", since_strobe);
                        end
                    end
                    since_strobe = 0;
                end
            end else begin
                if (align_run != 0) begin
                    checks++;
                    if (align_run != 2) begin
                        errors++;
                        $display("FAIL stream_align_run: got %0d ALIGNp required 2", align_run);
                    end
                    align_run = 0;
                end
                checks++;
                if (data_out !== dw(exp_idx) || charisk_out !== ck(exp_idx) || align_strobe !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_data: data=%h k=%h stb=%b required %h %h 0",
                             data_out, charisk_out, align_strobe, dw(exp_idx), ck(exp_idx));
                end
                exp_idx++;
                data_run++;
            end
        end
        checks++;
        if (strobes != 11) begin
            errors++;
            $display("FAIL stream_strobe_count: got %0d required 11", strobes);
        end
    endtask

    // One-cycle PHY drop at cnt=100, then the ALIGN1 drop scenario
    task automatic test_phy_drop();
        bit found = 0;
        int n = 1;
        do_reset();
        for (int j = 0; j < 200; j++) begin
            cyc();
            if (data_out === dw(99)) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found || ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_reach_d99: found=%0d rdy=%b required 1 1", found, ready);
        end
        phy_ready = 1'b0;
        cyc();
        checks++;
        if (data_out !== c_align || ready !== 1'b0 || forcing !== 1'b1) begin
            errors++;
            $display("FAIL drop_first_align: data=%h rdy=%b frc=%b required %h 0 1",
                     data_out, ready, forcing, c_align);
        end
        phy_ready = 1'b1;
        cyc();
        checks++;
        if (data_out !== c_align || ready !== 1'b1 || forcing !== 1'b0) begin
            errors++;
            $display("FAIL drop_second_align: data=%h rdy=%b frc=%b required %h 1 0",
                     data_out, ready, forcing, c_align);
        end
        cyc();
        checks++;
        if (data_out !== dw(100)) begin
            errors++;
            $display("FAIL drop_resume: data=%h required %h", data_out, dw(100));
        end
        found = 0;
        for (int j = 0; j < 400; j++) begin
            if (ready === 1'b0) begin
                found = 1;
                break;
            end
            cyc();
            n++;
        end
        checks++;
        if (!found || n != 254 || data_out !== dw(353)) begin
            errors++;
            $display("FAIL drop_next_pair: found=%0d run=%0d last=%h required 1 254 %h",
                     found, n, data_out, dw(353));
        end
        // Now in ALIGN1: drop PHY for 3 cycles, expect 4 ALIGNp total
        phy_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cyc();
            checks++;
            if (data_out !== c_align || forcing !== 1'b1 || align_strobe !== 1'b0 || ready !== 1'b0) begin
                errors++;
                $display("FAIL align1_drop_low%0d: data=%h frc=%b stb=%b rdy=%b required %h 1 0 0",
                         j, data_out, forcing, align_strobe, ready, c_align);
            end
        end
        phy_ready = 1'b1;
        cyc();
        checks++;
        if (data_out !== c_align || ready !== 1'b1 || forcing !== 1'b0 || align_strobe !== 1'b0) begin
            errors++;
            $display("FAIL align1_drop_pad: data=%h rdy=%b frc=%b stb=%b required %h 1 0 0",
                     data_out, ready, forcing, align_strobe, c_align);
        end
        cyc();
        checks++;
        if (data_out !== dw(354) || charisk_out !== ck(354)) begin
            errors++;
            $display("FAIL align1_drop_resume: data=%h k=%h required %h %h",
                     data_out, charisk_out, dw(354), ck(354));
        end
    endtask

    task automatic test_rst_align2();
        bit found = 0;
        for (int j = 0; j < 400; j++) begin
            cyc();
            if (ready === 1'b0) begin
                found = 1;
                break;
            end
        end
        cyc();
        checks++;
        if (!found || data_out !== c_align || align_strobe !== 1'b0) begin
            errors++;
            $display("FAIL rst_a2_setup: found=%0d data=%h stb=%b required 1 %h 0",
                     found, data_out, align_strobe, c_align);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (data_out !== c_align || charisk_out !== 4'h1 || ready !== 1'b0 ||
            align_strobe !== 1'b0 || forcing !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_align2: data=%h k=%h rdy=%b stb=%b frc=%b required %h 1 0 0 1",
                     data_out, charisk_out, ready, align_strobe, forcing, c_align);
        end
        rst = 1'b0;
    endtask

    task automatic test_period1();
        do_reset();
        cyc();
        checks++;
        if (data_out1 !== c_align || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL p1_first_align: data=%h rdy=%b required %h 0", data_out1, ready1, c_align);
        end
        cyc();
        checks++;
        if (data_out1 !== c_align || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL p1_second_align: data=%h rdy=%b required %h 1", data_out1, ready1, c_align);
        end
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++;
            if (data_out1 !== dw1(k) || ready1 !== 1'b0 || align_strobe1 !== 1'b0) begin
                errors++;
                $display("FAIL p1_data%0d: data=%h rdy=%b stb=%b required %h 0 0",
                         k, data_out1, ready1, align_strobe1, dw1(k));
            end
            cyc();
            checks++;
            if (data_out1 !== c_align || ready1 !== 1'b0 || align_strobe1 !== 1'b0) begin
                errors++;
                $display("FAIL p1_alignA%0d: data=%h rdy=%b stb=%b required %h 0 0",
                         k, data_out1, ready1, align_strobe1, c_align);
            end
            cyc();
            checks++;
            if (data_out1 !== c_align || ready1 !== 1'b1 || align_strobe1 !== 1'b1) begin
                errors++;
                $display("FAIL p1_alignB%0d: data=%h rdy=%b stb=%b required %h 1 1",
                         k, data_out1, ready1, align_strobe1, c_align);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        phy_ready = 1'b0;
        drive();
        test_reset();
        test_stream();
        test_phy_drop();
        test_rst_align2();
        test_period1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
